pipeline_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RV64 pipeline. Drives the write-enables and

---
 rtl/pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, memory-wait freeze.
// Optional performance counters are enabled with `define HAZ_PERF_CNT_EN.
//
// state | meaning
// RUN   | normal issue; load-use bubbles and branch redirects handled here
// FLUSH | IF/ID and ID/EX load NOPs while the redirected fetch arrives (fcnt cycles)
// HOLD  | data memory busy; everything frozen, pre-freeze state kept in saved_q
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_DEPTH = 1
`ifdef HAZ_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] hold_cnt,
`endif
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_DEPTH);

  state_e     state_q, state_d;
  state_e     saved_q, saved_d;
  logic [3:0] fcnt_q, fcnt_d;
  state_e     eff_state;
  logic       load_use;
  logic       stall_evt, redirect_evt;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  // Leaving HOLD behaves exactly as the state that was frozen.
  assign eff_state = (state_q == ST_HOLD) ? saved_q : state_q;

  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    fcnt_d       = fcnt_q;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_we    = 1'b0;
    stall_evt    = 1'b0;
    redirect_evt = 1'b0;

    if (reset) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = ST_RUN;
      saved_d     = ST_RUN;
      fcnt_d      = 4'd0;
    end else if (mem_busy) begin
      if (state_q != ST_HOLD) saved_d = state_q;
      state_d = ST_HOLD;
    end else begin
      case (eff_state)
        ST_FLUSH: begin
          pc_we       = 1'b1;
          if_id_we    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_we    = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_we   = 1'b1;
          if (ex_branch_taken) begin
            redirect_evt = 1'b1;
            fcnt_d       = FLUSH_LD;
            state_d      = ST_FLUSH;
          end else begin
            fcnt_d  = fcnt_q - 4'd1;
            state_d = (fcnt_q <= 4'd1) ? ST_RUN : ST_FLUSH;
          end
        end
        default: begin
          state_d = ST_RUN;
          if (ex_branch_taken) begin
            redirect_evt = 1'b1;
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_we     = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_we    = 1'b1;
            if (FLUSH_DEPTH != 0) begin
              state_d = ST_FLUSH;
              fcnt_d  = FLUSH_LD;
            end
          end else if (load_use) begin
            stall_evt   = 1'b1;
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
          end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      saved_q <= ST_RUN;
      fcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign state_o = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  // Saturating event counters.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    hold_d  = hold_q;
    if (stall_evt && (stall_q != '1))                 stall_d = stall_q + 1'b1;
    if (redirect_evt && (flush_q != '1))              flush_d = flush_q + 1'b1;
    if ((state_q == ST_HOLD) && (hold_q != '1))       hold_d  = hold_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
      hold_q  <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      hold_q  <= hold_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign hold_cnt  = hold_q;
`endif

endmodule
